spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder_if.sv | 30 +++
 rtl/spike_rate_decoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if
//   Groups the spike input, window enable and rate result handshake of the
//   spike rate decoder into one bundle.
//   master : drives en, spike_in, rate_ready; observes the result side.
//   slave  : the decoder itself; drives rate, rate_hot, rate_valid,
//            overrun and busy.
//   Handshake: rate_valid/rate_ready form a valid/ready pair. A transfer
//   happens on any rising edge where both are 1. While rate_valid=1 and
//   rate_ready=0, rate is held stable. rate_valid is registered and never
//   depends combinationally on rate_ready.
interface spike_rate_decoder_if;
  logic       en;
  logic       spike_in;
  logic       rate_ready;
  logic [3:0] rate;
  logic       rate_hot;
  logic       rate_valid;
  logic       overrun;
  logic       busy;

  modport master (
    output en, spike_in, rate_ready,
    input  rate, rate_hot, rate_valid, overrun, busy
  );

  modport slave (
    input  en, spike_in, rate_ready,
    output rate, rate_hot, rate_valid, overrun, busy
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Counts spikes over a fixed window of WIN clock cycles and presents the
//   count as a rate with a valid/ready handshake. Windows run back-to-back
//   while en is held high. A result completed while the previous one is
//   still unconsumed is dropped and flagged in the sticky overrun bit.
// Parameters
//   WIN    : window length in cycles, 1..15
//   THRESH : rate_hot threshold, 0..15
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : spike_rate_decoder_if.slave
//            en, spike_in, rate_ready (in)
//            rate, rate_hot, rate_valid, overrun, busy (out)
module spike_rate_decoder #(
  parameter int WIN    = 15,
  parameter int THRESH = 8
) (
  input logic                 clk,
  input logic                 rst,
  spike_rate_decoder_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_CYC = 4'(WIN - 1);
  localparam logic [3:0] THRESH_L = 4'(THRESH);

  state_t     state, state_next;
  logic [3:0] cyc, cyc_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] rate_q;
  logic       rate_valid_q;
  logic       overrun_q;

  logic       complete;
  logic [3:0] result;

  // A window closes on its last cycle only while en is still high; the
  // spike sampled on that cycle is part of the result.
  assign complete = (state == COUNT) && bus.en && (cyc == LAST_CYC);
  assign result   = cnt + {3'b000, bus.spike_in};

  always_comb begin
    state_next = state;
    cyc_next   = cyc;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        cyc_next = 4'd0;
        cnt_next = 4'd0;
        if (bus.en) state_next = COUNT;
      end
      COUNT: begin
        if (!bus.en) begin
          // Partial window is abandoned.
          state_next = IDLE;
          cyc_next   = 4'd0;
          cnt_next   = 4'd0;
        end else if (complete) begin
          // Next window starts on the very next cycle.
          cyc_next = 4'd0;
          cnt_next = 4'd0;
        end else begin
          cyc_next = cyc + 4'd1;
          cnt_next = result;
        end
      end
      default: begin
        state_next = IDLE;
        cyc_next   = 4'd0;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cyc          <= 4'd0;
      cnt          <= 4'd0;
      rate_q       <= 4'd0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state <= state_next;
      cyc   <= cyc_next;
      cnt   <= cnt_next;
      if (complete) begin
        // Load when the output slot is empty or being emptied this cycle;
        // otherwise the new result is lost.
        if (!rate_valid_q || bus.rate_ready) begin
          rate_q       <= result;
          rate_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rate_valid_q && bus.rate_ready) begin
        rate_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.rate_hot   = (rate_q >= THRESH_L);
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state == COUNT);

endmodule
